// File: rtl/tx_char_scheduler.sv
// Character scheduler for the chat-link serial transmitter: round-robin arbitration between
// two sources, byte capture, load strobe, baud tick generation, send timeout and inter-char gap.
module tx_char_scheduler #(
   parameter int unsigned BAUD_DIV      = 434,
   parameter int unsigned GAP_CYCLES    = 8,
   parameter int unsigned TIMEOUT_TICKS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_i,
   input  logic [7:0] data0_i,
   input  logic       req1_i,
   input  logic [7:0] data1_i,
   input  logic       charSent_i,
   output logic       grant0_o,
   output logic       grant1_o,
   output logic [7:0] txData_o,
   output logic       load_o,
   output logic       transEn_o,
   output logic       srClock_o,
   output logic       busy_o,
   output logic       txErr_o
);

   localparam int unsigned TickW = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);
   localparam int unsigned GapW  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

   localparam logic [15:0]      BaudLast  = 16'(BAUD_DIV - 1);
   localparam logic [TickW-1:0] TickLimit = TickW'(TIMEOUT_TICKS);
   localparam logic [GapW-1:0]  GapLast   = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StSend, StDone, StGap} state_e;

   state_e           state_q, state_d;
   logic [15:0]      baud_q, baud_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic             last_q, last_d;
   logic [7:0]       txData_q, txData_d;
   logic             grant0_q, grant0_d;
   logic             grant1_q, grant1_d;
   logic             err_q, err_d;
   logic             load_q, transEn_q, srClock_q, busy_q;

   // Next-state, arbitration and counter updates.
   always_comb begin
      state_d  = state_q;
      baud_d   = '0;
      tick_d   = '0;
      gap_d    = '0;
      last_d   = last_q;
      txData_d = txData_q;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // On a tie the source that was not served last wins.
            if (req0_i && (!req1_i || last_q)) begin
               grant0_d = 1'b1;
               txData_d = data0_i;
               last_d   = 1'b0;
               state_d  = StLoad;
            end else if (req1_i) begin
               grant1_d = 1'b1;
               txData_d = data1_i;
               last_d   = 1'b1;
               state_d  = StLoad;
            end
         end
         StLoad: state_d = StSend;
         StSend: begin
            baud_d = (baud_q == BaudLast) ? 16'd0 : baud_q + 16'd1;
            tick_d = (baud_q == BaudLast) ? tick_q + 1'b1 : tick_q;
            // A completed frame wins over a timeout in the same cycle.
            if (charSent_i) begin
               state_d = StDone;
            end else if (tick_q == TickLimit) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StDone: state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
         StGap: begin
            if (gap_q == GapLast) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; load/transEn/srClock follow the current state one cycle late.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         tick_q    <= '0;
         gap_q     <= '0;
         last_q    <= 1'b1;
         txData_q  <= 8'h00;
         grant0_q  <= 1'b0;
         grant1_q  <= 1'b0;
         err_q     <= 1'b0;
         load_q    <= 1'b0;
         transEn_q <= 1'b0;
         srClock_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         tick_q    <= tick_d;
         gap_q     <= gap_d;
         last_q    <= last_d;
         txData_q  <= txData_d;
         grant0_q  <= grant0_d;
         grant1_q  <= grant1_d;
         err_q     <= err_d;
         load_q    <= (state_q == StLoad);
         transEn_q <= (state_q == StSend);
         srClock_q <= (state_q == StSend) && (baud_q == BaudLast);
         busy_q    <= (state_d != StIdle);
      end
   end

   assign grant0_o  = grant0_q;
   assign grant1_o  = grant1_q;
   assign txData_o  = txData_q;
   assign load_o    = load_q;
   assign transEn_o = transEn_q;
   assign srClock_o = srClock_q;
   assign busy_o    = busy_q;
   assign txErr_o   = err_q;

endmodule

// File: tb/tb_tx_char_scheduler.sv
// Directed bench for tx_char_scheduler: cycle table for the first character, then
// hand-written sequences for completion, round-robin, timeout, reset and zero-gap cases.
module tb_tx_char_scheduler;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0, charSent = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       grant0, grant1, load, transEn, srClock, busy, txErr;
   logic [7:0] txData;

   logic       req0_b = 1'b0, req1_b = 1'b0, charSent_b = 1'b0;
   logic [7:0] data0_b = 8'h00, data1_b = 8'h00;
   logic       grant0_b, grant1_b, load_b, transEn_b, srClock_b, busy_b, txErr_b;
   logic [7:0] txData_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tx_char_scheduler #(.BAUD_DIV(4), .GAP_CYCLES(2), .TIMEOUT_TICKS(16)) dut (
      .clk(clk), .rst(rst), .req0_i(req0), .data0_i(data0), .req1_i(req1), .data1_i(data1),
      .charSent_i(charSent), .grant0_o(grant0), .grant1_o(grant1), .txData_o(txData),
      .load_o(load), .transEn_o(transEn), .srClock_o(srClock), .busy_o(busy), .txErr_o(txErr)
   );

   tx_char_scheduler #(.BAUD_DIV(4), .GAP_CYCLES(0), .TIMEOUT_TICKS(16)) dut_b (
      .clk(clk), .rst(rst), .req0_i(req0_b), .data0_i(data0_b), .req1_i(req1_b),
      .data1_i(data1_b), .charSent_i(charSent_b), .grant0_o(grant0_b), .grant1_o(grant1_b),
      .txData_o(txData_b), .load_o(load_b), .transEn_o(transEn_b), .srClock_o(srClock_b),
      .busy_o(busy_b), .txErr_o(txErr_b)
   );

   logic [14:0] obs;
   assign obs = {grant0, grant1, txData, load, transEn, srClock, busy, txErr};

   typedef struct {
      logic       rst;
      logic       req0;
      logic [7:0] data0;
      logic       req1;
      logic [7:0] data1;
      logic       cs;
      logic       g0;
      logic       g1;
      logic [7:0] txd;
      logic       ld;
      logic       te;
      logic       sc;
      logic       bsy;
      logic       err;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output logic found, output logic g0, output logic g1,
                             output logic [7:0] d);
      found = 1'b0;
      g0    = 1'b0;
      g1    = 1'b0;
      d     = 8'h00;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (grant0 || grant1) begin
            found = 1'b1;
            g0    = grant0;
            g1    = grant1;
            d     = txData;
         end
      end
   endtask

   task automatic wait_ticks(input int n, output logic ok, output logic err_seen);
      int seen = 0;
      ok       = 1'b0;
      err_seen = 1'b0;
      for (int i = 0; i < n * 4 + 20 && seen < n; i++) begin
         step();
         if (txErr) err_seen = 1'b1;
         if (srClock) seen++;
      end
      ok = (seen == n);
   endtask

   task automatic wait_idle(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         step();
         if (!busy) ok = 1'b1;
      end
   endtask

   initial begin
      logic       found, g0, g1, ok, err_seen;
      logic [7:0] d;
      logic [7:0] exp_d;

      //          rst req0 d0     req1 d1     cs  g0 g1 txd    ld te sc bsy err
      vecs[0]  = '{H, L, 8'h00, L, 8'h00, L, L, L, 8'h00, L, L, L, L, L};
      vecs[1]  = '{L, H, 8'h41, L, 8'h00, L, H, L, 8'h41, L, L, L, H, L};
      vecs[2]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, H, L, L, H, L};
      vecs[3]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, L, H, L};
      vecs[4]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, L, H, L};
      vecs[5]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, L, H, L};
      vecs[6]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, H, H, L};
      vecs[7]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, L, H, L};
      vecs[8]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, L, H, L};
      vecs[9]  = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, L, H, L};
      vecs[10] = '{L, L, 8'h41, L, 8'h00, L, L, L, 8'h41, L, H, H, H, L};

      // First character: reset, grant, load, transEn, two baud ticks.
      for (int i = 0; i < 11; i++) begin
         rst      = vecs[i].rst;
         req0     = vecs[i].req0;
         data0    = vecs[i].data0;
         req1     = vecs[i].req1;
         data1    = vecs[i].data1;
         charSent = vecs[i].cs;
         step();
         check($sformatf("vec%0d", i), {1'b0, obs},
               {1'b0, vecs[i].g0, vecs[i].g1, vecs[i].txd, vecs[i].ld, vecs[i].te, vecs[i].sc,
                vecs[i].bsy, vecs[i].err});
      end

      // Frame completes after the 11th tick: DONE + 2 GAP cycles, then idle.
      wait_ticks(9, ok, err_seen);
      check("ticks_to_11", 16'(ok), 16'd1);
      check("no_err_before_sent", 16'(err_seen), 16'd0);
      charSent = 1'b1;
      step();
      charSent = 1'b0;
      check("sent_edge_busy_err", {14'd0, busy, txErr}, 16'b10);
      step();
      check("done_te_busy", {14'd0, transEn, busy}, 16'b01);
      step();
      check("gap1_te_busy", {14'd0, transEn, busy}, 16'b01);
      step();
      check("gap2_idle", {13'd0, transEn, busy, txErr}, 16'b000);
      check("txdata_held", 16'(txData), 16'h0041);

      // Round-robin with both sources held high; first tie goes to source 0.
      rst = 1'b1;
      step();
      rst      = 1'b0;
      req0     = 1'b1;
      data0    = 8'h30;
      req1     = 1'b1;
      data1    = 8'h31;
      charSent = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_grant(found, g0, g1, d);
         exp_d = (k % 2 == 0) ? 8'h30 : 8'h31;
         check($sformatf("rr%0d_found", k), 16'(found), 16'd1);
         check($sformatf("rr%0d_grant", k), {14'd0, g0, g1},
               (k % 2 == 0) ? 16'b10 : 16'b01);
         check($sformatf("rr%0d_data", k), 16'(d), 16'(exp_d));
      end
      req0 = 1'b0;
      req1 = 1'b0;
      wait_idle(ok);
      check("rr_idle", 16'(ok), 16'd1);
      charSent = 1'b0;

      // Timeout: no charSent, txErr one cycle after the 16th tick.
      req0  = 1'b1;
      data0 = 8'h55;
      wait_grant(found, g0, g1, d);
      req0 = 1'b0;
      check("to_grant", {13'd0, found, g0, g1}, 16'b110);
      wait_ticks(16, ok, err_seen);
      check("to_16_ticks", 16'(ok), 16'd1);
      check("to_err_early", {14'd0, err_seen, txErr}, 16'b00);
      step();
      check("to_err_pulse", {14'd0, txErr, busy}, 16'b11);
      step();
      check("to_err_clear", 16'(txErr), 16'd0);
      wait_idle(ok);
      check("to_idle", 16'(ok), 16'd1);
      req1  = 1'b1;
      data1 = 8'h66;
      wait_grant(found, g0, g1, d);
      req1 = 1'b0;
      check("to_next_served", {5'd0, found, g0, g1, d}, {5'd0, 3'b101, 8'h66});

      // Reset mid-SEND after 5 ticks, with req1 pending.
      rst = 1'b1;
      step();
      rst   = 1'b0;
      req0  = 1'b1;
      data0 = 8'h12;
      wait_grant(found, g0, g1, d);
      req0 = 1'b0;
      check("rs_grant", {13'd0, found, g0, g1}, 16'b110);
      wait_ticks(5, ok, err_seen);
      check("rs_5_ticks", 16'(ok), 16'd1);
      req1  = 1'b1;
      data1 = 8'h9a;
      rst   = 1'b1;
      step();
      check("rs_outputs_zero", {1'b0, obs}, 16'd0);
      rst = 1'b0;
      step();
      check("rs_req1_granted", {1'b0, obs},
            {1'b0, 1'b0, 1'b1, 8'h9a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      req1 = 1'b0;

      // Zero-gap instance: DONE for one cycle, then next grant.
      rst = 1'b1;
      step();
      rst     = 1'b0;
      req1_b  = 1'b1;
      data1_b = 8'h77;
      step();
      check("g0_first_grant", {5'd0, grant0_b, grant1_b, txData_b}, {5'd0, 2'b01, 8'h77});
      step();
      check("g0_load", 16'(load_b), 16'd1);
      charSent_b = 1'b1;
      step();
      charSent_b = 1'b0;
      check("g0_sent_busy", {14'd0, grant1_b, busy_b}, 16'b01);
      step();
      check("g0_done", {13'd0, grant1_b, busy_b, txErr_b}, 16'b000);
      step();
      check("g0_regrant", {5'd0, grant1_b, busy_b, txData_b}, {5'd0, 2'b11, 8'h77});
      req1_b = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
